// File: rtl/snake_body_engine.sv
// Snake body datapath: direction, segment shift register, growth, move timer with
// speed-up, wall/self collision and the registered per-pixel head/body query.

module snake_seg_cmp #(
    parameter int IDX = 0,
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic [X_W-1:0] seg_x,
    input  logic [Y_W-1:0] seg_y,
    input  logic [X_W-1:0] pix_x,
    input  logic [Y_W-1:0] pix_y,
    input  logic [X_W-1:0] nxt_x,
    input  logic [Y_W-1:0] nxt_y,
    input  logic [6:0]     length,
    output logic           pix_hit,
    output logic           self_hit
);
    logic live, mid;

    // The tail (LENGTH-1) vacates its cell on the same move, so it is excluded from self-hit.
    assign live     = IDX < int'(length);
    assign mid      = (IDX >= 1) && (IDX + 2 <= int'(length));
    assign pix_hit  = live && (seg_x == pix_x) && (seg_y == pix_y);
    assign self_hit = mid && (seg_x == nxt_x) && (seg_y == nxt_y);
endmodule

module snake_body_engine #(
    parameter int MAX_LEN   = 32,
    parameter int INIT_LEN  = 2,
    parameter int GRID_W    = 160,
    parameter int GRID_H    = 120,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int START_X   = 80,
    parameter int START_Y   = 100,
    parameter int WRAP_MODE = 1,
    parameter int TICK_BASE = 2000000,
    parameter int TICK_DEC  = 50000,
    parameter int TICK_MIN  = 500000
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic           ENABLE,
    input  logic           RESTART,
    input  logic [1:0]     NAV_STATE,
    input  logic [X_W-1:0] TARGET_X,
    input  logic [Y_W-1:0] TARGET_Y,
    input  logic [X_W-1:0] PIX_X,
    input  logic [Y_W-1:0] PIX_Y,
    output logic           PIX_HEAD,
    output logic           PIX_BODY,
    output logic [X_W-1:0] HEAD_X,
    output logic [Y_W-1:0] HEAD_Y,
    output logic [6:0]     LENGTH,
    output logic           MOVE_STROBE,
    output logic           TARGET_REACHED,
    output logic           DEAD
);
    localparam int TW      = $clog2(TICK_BASE + 1);
    localparam int PER_THR = TICK_MIN + TICK_DEC;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_DEAD   = 1'b1;

    logic [MAX_LEN-1:0][X_W-1:0] seg_x;
    logic [MAX_LEN-1:0][Y_W-1:0] seg_y;
    logic [MAX_LEN-1:0]          pix_hit, self_vec;
    logic [1:0]                  dir, dir_nxt;
    logic [TW-1:0]               period, cnt, period_dec;
    logic [0:0]                  state;
    logic [6:0]                  length;
    logic [X_W-1:0]              nxt_x;
    logic [Y_W-1:0]              nxt_y;
    logic                        wall, collide, tgt, tick_end;

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_seg
        snake_seg_cmp #(.IDX(g), .X_W(X_W), .Y_W(Y_W)) u_cmp (
            .seg_x(seg_x[g]), .seg_y(seg_y[g]),
            .pix_x(PIX_X), .pix_y(PIX_Y),
            .nxt_x(nxt_x), .nxt_y(nxt_y),
            .length(length),
            .pix_hit(pix_hit[g]), .self_hit(self_vec[g])
        );
    end

    always_comb begin
        dir_nxt = (NAV_STATE == ~dir) ? dir : NAV_STATE;
        nxt_x   = seg_x[0];
        nxt_y   = seg_y[0];
        wall    = 1'b0;
        case (dir_nxt)
            DIR_UP:
                if (seg_y[0] == '0) begin
                    nxt_y = Y_W'(GRID_H - 1);
                    wall  = (WRAP_MODE == 0);
                end else nxt_y = seg_y[0] - Y_W'(1);
            DIR_LEFT:
                if (seg_x[0] == '0) begin
                    nxt_x = X_W'(GRID_W - 1);
                    wall  = (WRAP_MODE == 0);
                end else nxt_x = seg_x[0] - X_W'(1);
            DIR_RIGHT:
                if (seg_x[0] == X_W'(GRID_W - 1)) begin
                    nxt_x = '0;
                    wall  = (WRAP_MODE == 0);
                end else nxt_x = seg_x[0] + X_W'(1);
            default:
                if (seg_y[0] == Y_W'(GRID_H - 1)) begin
                    nxt_y = '0;
                    wall  = (WRAP_MODE == 0);
                end else nxt_y = seg_y[0] + Y_W'(1);
        endcase
    end

    assign collide    = wall | (|self_vec);
    assign tgt        = (nxt_x == TARGET_X) && (nxt_y == TARGET_Y);
    assign tick_end   = (cnt == period - TW'(1));
    // Floor at TICK_MIN without ever wrapping below zero.
    assign period_dec = (int'(period) >= PER_THR) ? period - TW'(TICK_DEC) : TW'(TICK_MIN);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            seg_x          <= {MAX_LEN{X_W'(START_X)}};
            seg_y          <= {MAX_LEN{Y_W'(START_Y)}};
            length         <= 7'(INIT_LEN);
            dir            <= DIR_RIGHT;
            period         <= TW'(TICK_BASE);
            cnt            <= '0;
            state          <= ST_RUN;
            MOVE_STROBE    <= 1'b0;
            TARGET_REACHED <= 1'b0;
        end else if (RESTART) begin
            seg_x          <= {MAX_LEN{X_W'(START_X)}};
            seg_y          <= {MAX_LEN{Y_W'(START_Y)}};
            length         <= 7'(INIT_LEN);
            dir            <= DIR_RIGHT;
            period         <= TW'(TICK_BASE);
            cnt            <= '0;
            state          <= ST_RUN;
            MOVE_STROBE    <= 1'b0;
            TARGET_REACHED <= 1'b0;
        end else begin
            MOVE_STROBE    <= 1'b0;
            TARGET_REACHED <= 1'b0;
            if (state == ST_RUN && ENABLE) begin
                if (tick_end) begin
                    cnt <= '0;
                    dir <= dir_nxt;
                    if (collide) state <= ST_DEAD;
                    else begin
                        seg_x       <= {seg_x[MAX_LEN-2:0], nxt_x};
                        seg_y       <= {seg_y[MAX_LEN-2:0], nxt_y};
                        MOVE_STROBE <= 1'b1;
                        if (tgt) begin
                            TARGET_REACHED <= 1'b1;
                            period         <= period_dec;
                            if (length < 7'(MAX_LEN)) length <= length + 7'(1);
                        end
                    end
                end else cnt <= cnt + TW'(1);
            end
        end
    end

    // Pixel query keeps running through RESTART and DEAD; only RESET_N clears it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PIX_HEAD <= 1'b0;
            PIX_BODY <= 1'b0;
        end else begin
            PIX_HEAD <= pix_hit[0];
            PIX_BODY <= |pix_hit[MAX_LEN-1:1];
        end
    end

    assign HEAD_X = seg_x[0];
    assign HEAD_Y = seg_y[0];
    assign LENGTH = length;
    assign DEAD   = (state == ST_DEAD);
endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: wrap and wall variants side by side, queue-based snake model.

module tb_snake_body_engine;
    localparam int MAX_LEN = 8, INIT_LEN = 2, GRID_W = 160, GRID_H = 120;
    localparam int SX = 80, SY = 100, TB_BASE = 4, TB_DEC = 1, TB_MIN = 2;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0, ENABLE = 1'b0, RESTART = 1'b0;
    logic [1:0] NAV_STATE = 2'b10;
    logic [7:0] TARGET_X = 8'd0, PIX_X = 8'd0;
    logic [6:0] TARGET_Y = 7'd0, PIX_Y = 7'd0;

    logic       ph_o[2], pb_o[2], ms_o[2], tr_o[2], dd_o[2];
    logic [7:0] hx_o[2];
    logic [6:0] hy_o[2], ln_o[2];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        snake_body_engine #(
            .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .GRID_W(GRID_W), .GRID_H(GRID_H),
            .X_W(8), .Y_W(7), .START_X(SX), .START_Y(SY), .WRAP_MODE(g == 0 ? 1 : 0),
            .TICK_BASE(TB_BASE), .TICK_DEC(TB_DEC), .TICK_MIN(TB_MIN)
        ) dut (
            .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .RESTART(RESTART),
            .NAV_STATE(NAV_STATE), .TARGET_X(TARGET_X), .TARGET_Y(TARGET_Y),
            .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_HEAD(ph_o[g]), .PIX_BODY(pb_o[g]),
            .HEAD_X(hx_o[g]), .HEAD_Y(hy_o[g]), .LENGTH(ln_o[g]),
            .MOVE_STROBE(ms_o[g]), .TARGET_REACHED(tr_o[g]), .DEAD(dd_o[g])
        );
    end

    // Model: snake as a queue of cells (x*256+y), head at front. Index 0 wraps, 1 has walls.
    int sq[2][$];
    int mdir[2], mcnt[2], mper[2], mdead[2], mms[2], mtr[2], mph[2], mpb[2];
    int tests = 0, fails = 0;
    bit pix_auto = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_restart(input int m);
        sq[m] = {};
        for (int i = 0; i < INIT_LEN; i++) sq[m].push_back(SX * 256 + SY);
        mdir[m] = 2; mcnt[m] = 0; mper[m] = TB_BASE; mdead[m] = 0; mms[m] = 0; mtr[m] = 0;
    endtask

    task automatic model_step(input int m);
        int nd, nx, ny, key, pk;
        bit hit;
        pk = int'(PIX_X) * 256 + int'(PIX_Y);
        mph[m] = (sq[m][0] == pk);
        mpb[m] = 0;
        for (int i = 1; i < sq[m].size(); i++) if (sq[m][i] == pk) mpb[m] = 1;
        mms[m] = 0; mtr[m] = 0;
        if (RESTART) begin model_restart(m); return; end
        if (mdead[m] != 0 || !ENABLE) return;
        if (mcnt[m] != mper[m] - 1) begin mcnt[m]++; return; end
        mcnt[m] = 0;
        nd = (int'(NAV_STATE) == (~mdir[m] & 3)) ? mdir[m] : int'(NAV_STATE);
        mdir[m] = nd;
        nx = sq[m][0] / 256 + (nd == 2 ? 1 : 0) - (nd == 1 ? 1 : 0);
        ny = sq[m][0] % 256 + (nd == 3 ? 1 : 0) - (nd == 0 ? 1 : 0);
        hit = 1'b0;
        if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
            if (m == 1) hit = 1'b1;
            nx = (nx + GRID_W) % GRID_W;
            ny = (ny + GRID_H) % GRID_H;
        end
        key = nx * 256 + ny;
        for (int i = 1; i <= sq[m].size() - 2; i++) if (sq[m][i] == key) hit = 1'b1;
        if (hit) begin mdead[m] = 1; return; end
        sq[m].push_front(key);
        mms[m] = 1;
        if (key == int'(TARGET_X) * 256 + int'(TARGET_Y)) begin
            mtr[m] = 1;
            mper[m] = (mper[m] - TB_DEC < TB_MIN) ? TB_MIN : mper[m] - TB_DEC;
            if (sq[m].size() > MAX_LEN) void'(sq[m].pop_back());
        end else void'(sq[m].pop_back());
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("hx%0d", m), int'(hx_o[m]), sq[m][0] / 256);
            chk($sformatf("hy%0d", m), int'(hy_o[m]), sq[m][0] % 256);
            chk($sformatf("len%0d", m), int'(ln_o[m]), sq[m].size());
            chk($sformatf("dead%0d", m), int'(dd_o[m]), mdead[m]);
            chk($sformatf("strobe%0d", m), int'(ms_o[m]), mms[m]);
            chk($sformatf("reached%0d", m), int'(tr_o[m]), mtr[m]);
            chk($sformatf("pixhead%0d", m), int'(ph_o[m]), mph[m]);
            chk($sformatf("pixbody%0d", m), int'(pb_o[m]), mpb[m]);
        end
    endtask

    task automatic drive_pix();
        int k, key;
        k = $urandom_range(0, 3);
        case (k)
            0: key = sq[0][0];
            1: key = sq[0][sq[0].size() - 1];
            2: key = SX * 256 + SY;
            default: key = $urandom_range(0, GRID_W - 1) * 256 + $urandom_range(95, 105);
        endcase
        PIX_X = 8'(key / 256);
        PIX_Y = 7'(key % 256);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step(0);
        model_step(1);
        @(negedge CLK);
        check_all();
        if (pix_auto) drive_pix();
    endtask

    task automatic wait_move(output int n);
        n = 0;
        do begin tick(); n++; end while (!ms_o[0] && n < 20);
        if (!ms_o[0]) begin fails++; tests++; $display("FAIL wait_move: no strobe, got 0 expected 1"); end
    endtask

    initial begin
        int n;
        model_restart(0); model_restart(1);
        mph = '{0, 0}; mpb = '{0, 0};
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        chk("rst_hx", int'(hx_o[0]), 80);
        chk("rst_len", int'(ln_o[0]), 2);
        chk("rst_dead", int'(dd_o[1]), 0);
        chk("rst_pix", int'(ph_o[0]), 0);

        ENABLE = 1'b1;
        repeat (4) tick();
        chk("t1_hx81", int'(hx_o[0]), 81);
        repeat (4) tick();
        chk("t1_hx82", int'(hx_o[0]), 82);

        NAV_STATE = 2'b01; wait_move(n);
        chk("t3_rev_ignored", int'(hx_o[0]), 83);
        NAV_STATE = 2'b00; wait_move(n);
        chk("t3_up_y99", int'(hy_o[0]), 99);
        NAV_STATE = 2'b10;

        TARGET_X = 8'd86; TARGET_Y = 7'd99;
        wait_move(n); wait_move(n); wait_move(n);
        chk("t4_reached", int'(tr_o[0]), 1);
        chk("t4_len3", int'(ln_o[0]), 3);
        TARGET_X = 8'd0; TARGET_Y = 7'd0;
        wait_move(n);
        chk("t4_period3", n, 3);

        tick(); ENABLE = 1'b0; repeat (5) tick(); ENABLE = 1'b1;

        n = 0;
        while (sq[0][0] / 256 != 159 && n < 2000) begin tick(); n++; end
        wait_move(n);
        chk("t2_wrap_hx0", int'(hx_o[0]), 0);
        chk("t2_wall_dead", int'(dd_o[1]), 1);
        chk("t2_wall_hx159", int'(hx_o[1]), 159);

        RESTART = 1'b1; tick(); RESTART = 1'b0;
        chk("restart_len", int'(ln_o[1]), 2);
        chk("restart_alive", int'(dd_o[1]), 0);

        TARGET_X = 8'd81; TARGET_Y = 7'd100; wait_move(n);
        TARGET_X = 8'd82; wait_move(n);
        TARGET_X = 8'd83; wait_move(n);
        TARGET_X = 8'd0; TARGET_Y = 7'd0;
        chk("t5_len5", int'(ln_o[0]), 5);
        NAV_STATE = 2'b00; wait_move(n);
        NAV_STATE = 2'b01; wait_move(n);
        NAV_STATE = 2'b11;
        n = 0;
        while (!dd_o[0] && n < 20) begin tick(); n++; end
        chk("t5_dead", int'(dd_o[0]), 1);
        repeat (6) tick();
        chk("t5_frozen_x", int'(hx_o[0]), 82);
        chk("t5_frozen_y", int'(hy_o[0]), 99);
        RESTART = 1'b1; tick(); RESTART = 1'b0;
        chk("t5_len2", int'(ln_o[0]), 2);
        chk("t5_head", int'(hx_o[0]) * 256 + int'(hy_o[0]), 80 * 256 + 100);

        NAV_STATE = 2'b10;
        wait_move(n); wait_move(n);
        pix_auto = 1'b0;
        PIX_X = 8'd80; PIX_Y = 7'd100; tick();
        chk("t6_stale_body", int'(pb_o[0]), 0);
        PIX_X = 8'd81; tick();
        chk("t6_live_body", int'(pb_o[0]), 1);
        PIX_X = 8'd82; tick();
        chk("t6_head", int'(ph_o[0]), 1);
        #2 RESET_N = 1'b0;
        model_restart(0); model_restart(1);
        mph = '{0, 0}; mpb = '{0, 0};
        #1;
        chk("t6_rst_hx", int'(hx_o[0]), 80);
        chk("t6_rst_len", int'(ln_o[0]), 2);
        chk("t6_rst_pix", int'(ph_o[0]), 0);
        chk("t6_rst_strobe", int'(ms_o[1]), 0);
        #1 RESET_N = 1'b1;
        pix_auto = 1'b1;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
